// File: rtl/aha_ahb_code_loader.sv
// AHB-Lite write master that streams boot words into the code region.
// One single-beat NONSEQ write per accepted stream word.
module aha_ahb_code_loader #(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             aborted,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] words_written,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [1:0]       HRESP
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] ww_q, ww_d;
  logic [31:0]      wbuf_q, wbuf_d;
  logic             err_q, err_d;
  logic             abt_q, abt_d;
  logic [31:0]      eaddr_q, eaddr_d;

  // Only the ERROR bit of HRESP carries meaning here.
  logic unused_hresp;
  assign unused_hresp = HRESP[1];

  // Bus and status outputs decode straight from state and registers.
  assign s_ready       = (state_q == S_FETCH);
  assign busy          = (state_q == S_FETCH) ||
                         (state_q == S_ADDR)  ||
                         (state_q == S_DATA);
  assign done          = (state_q == S_DONE);
  assign error         = err_q;
  assign aborted       = abt_q;
  assign err_addr      = eaddr_q;
  assign words_written = ww_q;
  assign HADDR         = addr_q;
  assign HTRANS        = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HWRITE        = (state_q == S_ADDR);
  assign HSIZE         = 3'b010;
  assign HBURST        = 3'b000;
  assign HWDATA        = wbuf_q;

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    ww_d    = ww_q;
    wbuf_d  = wbuf_q;
    err_d   = err_q;
    abt_d   = abt_q;
    eaddr_d = eaddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          abt_d = 1'b0;
          ww_d  = '0;
          if (word_count != '0) begin
            addr_d  = {base_addr[31:2], 2'b00};
            rem_d   = word_count;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (abort) begin
          abt_d   = 1'b1;
          state_d = S_DONE;
        end else if (s_valid) begin
          wbuf_d  = s_data;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (HREADY) begin
          if (HRESP[0]) begin
            err_d   = 1'b1;
            eaddr_d = addr_q;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 32'd4;
            rem_d   = rem_q - CNT_W'(1);
            ww_d    = ww_q + CNT_W'(1);
            state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any transfer in flight.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      ww_q    <= '0;
      wbuf_q  <= '0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      ww_q    <= ww_d;
      wbuf_q  <= wbuf_d;
      err_q   <= err_d;
      abt_q   <= abt_d;
      eaddr_q <= eaddr_d;
    end
  end

endmodule

// File: tb/tb_aha_ahb_code_loader.sv
// Directed bench for aha_ahb_code_loader.
// Reactive AHB slave and stream source run on the falling edge.
module tb_aha_ahb_code_loader;
  localparam int CW = 16;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          abort = 1'b0;
  logic          s_valid, s_ready;
  logic [31:0]   s_data;
  logic          busy, done, error, aborted;
  logic [31:0]   err_addr;
  logic [CW-1:0] words_written;
  logic [31:0]   HADDR, HWDATA;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE, HBURST;
  logic          HWRITE;
  logic          HREADY;
  logic [1:0]    HRESP;

  aha_ahb_code_loader #(.CNT_W(CW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start),
    .base_addr(base_addr), .word_count(word_count),
    .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .busy(busy), .done(done),
    .error(error), .aborted(aborted), .err_addr(err_addr),
    .words_written(words_written), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int napp = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    napp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // stream source / slave state
  int          n_acc = 0;
  int          n0 = 0;
  logic [31:0] dbase = '0;
  bit          sv_en = 1'b0;
  int          sv_lim = 0;
  int          wa = 0;
  int          wd = 0;
  int          unstable = 0;
  int          nxfer = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  bit          dph = 1'b0;
  bit          derr = 1'b0;
  int          acnt = 0;
  int          dcnt = 0;
  logic [31:0] daddr, ahold, dhold;

  initial begin
    HREADY = 1'b1;
    HRESP = 2'b00;
    s_valid = 1'b0;
    s_data = '0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dph = 1'b0;
        acnt = 0;
        HREADY = 1'b1;
        HRESP = 2'b00;
        s_valid = 1'b0;
        continue;
      end
      s_valid = sv_en && ((n_acc - n0) < sv_lim);
      s_data = dbase + 32'(n_acc - n0);
      if (s_valid && s_ready && !abort) n_acc++;
      if (dph) begin
        if (dcnt == 0) dhold = HWDATA;
        else if (HWDATA !== dhold) unstable++;
        if (HTRANS !== 2'b00) unstable++;
        if (dcnt < wd) begin
          HREADY = 1'b0; HRESP = 2'b00;
        end else if (derr && dcnt == wd) begin
          HREADY = 1'b0; HRESP = 2'b01;
        end else begin
          HREADY = 1'b1; HRESP = derr ? 2'b01 : 2'b00;
        end
        dcnt++;
        if (HREADY) begin
          wr_addr.push_back(daddr);
          wr_data.push_back(HWDATA);
          dph = 1'b0;
        end
      end else if (HTRANS == 2'b10) begin
        if (acnt == 0) ahold = HADDR;
        else if (HADDR !== ahold) unstable++;
        if (HWRITE !== 1'b1) unstable++;
        HRESP = 2'b00;
        HREADY = (acnt >= wa);
        acnt++;
        if (HREADY) begin
          daddr = HADDR;
          derr = (HADDR > 32'h0001_FFFF);
          dph = 1'b1;
          dcnt = 0;
          acnt = 0;
          nxfer++;
        end
      end else begin
        HREADY = 1'b1;
        HRESP = 2'b00;
        if (HWRITE !== 1'b0) unstable++;
      end
    end
  end

  task automatic setup_stream(input logic [31:0] db, input int lim);
    n0 = n_acc;
    dbase = db;
    sv_lim = lim;
    sv_en = 1'b1;
  endtask

  task automatic pulse_start(input logic [31:0] b, input int c);
    @(posedge HCLK); #2;
    start = 1'b1;
    base_addr = b;
    word_count = c[CW-1:0];
    @(posedge HCLK); #1;
    start = 1'b0;
  endtask

  // cyc = edges after the start-sampling edge until done is seen
  task automatic wait_done(output int cyc);
    cyc = -1;
    if (done) cyc = 0;
    for (int k = 1; k <= 300 && cyc < 0; k++) begin
      @(posedge HCLK); #1;
      if (done) cyc = k;
    end
  endtask

  typedef struct {
    logic [31:0] base;
    int          cnt;
    int          wa;
    int          wd;
    int          cyc;
    int          ww;
    bit          err;
    logic [31:0] eaddr;
    int          nwr;
  } vec_t;

  vec_t tv[6];

  initial begin
    int cyc, x0, w0, ok;
    logic [31:0] db, ab;

    tv[0] = '{32'h0000_0100, 4, 0, 0, 12, 4, 1'b0, 32'h0, 4};
    tv[1] = '{32'h0000_0200, 3, 2, 3, 24, 3, 1'b0, 32'h0, 3};
    tv[2] = '{32'h0001_FFF8, 4, 0, 0, 10, 2, 1'b1, 32'h0002_0000, 3};
    tv[3] = '{32'h0000_0103, 1, 0, 0, 3, 1, 1'b0, 32'h0002_0000, 1};
    tv[4] = '{32'h0001_FFFC, 2, 1, 1, 11, 1, 1'b1, 32'h0002_0000, 2};
    tv[5] = '{32'h0000_0300, 0, 0, 0, 0, 0, 1'b0, 32'h0002_0000, 0};

    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_hwrite", HWRITE, 1'b0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_sready", s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_erraddr", err_addr, 32'h0);
    chk("rst_ww", words_written, 0);
    chk("hsize", HSIZE, 3'b010);
    chk("hburst", HBURST, 3'b000);
    #1 HRESET = 1'b0;

    for (int i = 0; i < 6; i++) begin
      db = (i == 0) ? 32'hA0 : (32'hC0DE_0000 + 32'(i << 8));
      wa = tv[i].wa;
      wd = tv[i].wd;
      x0 = nxfer;
      w0 = wr_addr.size();
      setup_stream(db, tv[i].cnt);
      pulse_start(tv[i].base, tv[i].cnt);
      wait_done(cyc);
      chk($sformatf("v%0d_cycles", i), cyc, tv[i].cyc);
      chk($sformatf("v%0d_ww", i), words_written, tv[i].ww);
      chk($sformatf("v%0d_error", i), error, tv[i].err);
      chk($sformatf("v%0d_erraddr", i), err_addr, tv[i].eaddr);
      chk($sformatf("v%0d_aborted", i), aborted, 1'b0);
      chk($sformatf("v%0d_nxfer", i), nxfer - x0, tv[i].nwr);
      chk($sformatf("v%0d_nlog", i), wr_addr.size() - w0, tv[i].nwr);
      ab = {tv[i].base[31:2], 2'b00};
      for (int j = 0; j < tv[i].nwr && w0 + j < wr_addr.size(); j++) begin
        chk($sformatf("v%0d_addr%0d", i, j), wr_addr[w0+j],
            ab + 32'(4 * j));
        chk($sformatf("v%0d_data%0d", i, j), wr_data[w0+j],
            db + 32'(j));
      end
      @(posedge HCLK); #1;
      chk($sformatf("v%0d_done1", i), done, 1'b0);
      chk($sformatf("v%0d_busy", i), busy, 1'b0);
      chk($sformatf("v%0d_sready", i), s_ready, 1'b0);
      chk($sformatf("v%0d_stable", i), unstable, 0);
      sv_en = 1'b0;
    end

    // abort while stalled waiting for word 2
    wa = 0; wd = 0;
    x0 = nxfer;
    setup_stream(32'hB0, 1);
    pulse_start(32'h400, 3);
    ok = 0;
    for (int k = 0; k < 50 && ok == 0; k++) begin
      @(posedge HCLK); #1;
      if (words_written == 1 && s_ready) ok = 1;
    end
    chk("ab_reach_fetch", ok, 1);
    repeat (2) @(posedge HCLK);
    #1 abort = 1'b1;
    @(posedge HCLK); #1;
    abort = 1'b0;
    chk("ab_done", done, 1'b1);
    chk("ab_aborted", aborted, 1'b1);
    chk("ab_ww", words_written, 1);
    chk("ab_error", error, 1'b0);
    repeat (3) @(posedge HCLK);
    #1;
    chk("ab_nxfer", nxfer - x0, 1);
    sv_en = 1'b0;
    pulse_start(32'h0, 0);
    wait_done(cyc);
    chk("zero_cycles", cyc, 0);
    chk("zero_busy", busy, 1'b0);
    chk("ab_cleared", aborted, 1'b0);

    // start while busy is ignored
    wa = 0; wd = 2;
    x0 = nxfer;
    setup_stream(32'hD0, 2);
    pulse_start(32'h500, 2);
    repeat (3) @(posedge HCLK);
    pulse_start(32'h600, 5);
    wait_done(cyc);
    chk("bs_done_seen", (cyc > 0), 1'b1);
    chk("bs_ww", words_written, 2);
    chk("bs_nxfer", nxfer - x0, 2);
    chk("bs_last_addr", wr_addr[$], 32'h504);
    sv_en = 1'b0;

    // reset in the data phase
    wa = 0; wd = 5;
    setup_stream(32'hE0, 3);
    pulse_start(32'h700, 3);
    ok = 0;
    for (int k = 0; k < 50 && ok == 0; k++) begin
      if (HTRANS == 2'b10) ok = 1;
      else begin
        @(posedge HCLK); #1;
      end
    end
    chk("rs_reach_addr", ok, 1);
    @(posedge HCLK); #2;
    HRESET = 1'b1;
    #1;
    chk("rs_htrans", HTRANS, 2'b00);
    chk("rs_busy", busy, 1'b0);
    chk("rs_haddr", HADDR, 32'h0);
    @(posedge HCLK); #2;
    HRESET = 1'b0;
    wd = 0;
    setup_stream(32'hF0, 1);
    pulse_start(32'h800, 1);
    wait_done(cyc);
    chk("rs_cycles", cyc, 3);
    chk("rs_ww", words_written, 1);
    chk("rs_addr", wr_addr[$], 32'h800);
    chk("rs_data", wr_data[$], 32'hF0);
    chk("rs_stable", unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", napp, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
